event_readout_ctrl: RTL and testbench

- Sequences a pixel arbitration hierarchy: drives its enable, captures each granted pixel address when active, timestamps it, and buffers it.
- Presents events on a valid/ready stream to the downstream readout.
- Throttles the hierarchy when the buffer nears full.
- Detects end of frame from group release.

---
 rtl/erc_pkg.sv | 21 ++
 rtl/evt_sync_fifo.sv | 56 +++++
 rtl/event_readout_ctrl.sv | 157 +++++++++++++++
 tb/tb_event_readout_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/erc_pkg.sv
// Shared types and constants for the event readout controller.
// Optional build macro: EVT_FRAME_MARKER_EN (frame marker words).
package erc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD,
        DONE
    } erc_state_e;

    // Slots kept free for the hierarchy's trailing grant after throttling.
    localparam int HOLD_MARGIN   = 2;
    // Fill level at or below which scanning may resume from HOLD.
    localparam int RESUME_MARGIN = 4;

    function automatic int evt_w(input int ts_w, input int x_w, input int y_w);
        return 1 + ts_w + x_w + y_w;
    endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Synchronous FIFO with first-word fall-through output.
// DEPTH must be a power of two; pointers wrap naturally.
module evt_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a word when the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);
    // Empty output reads as zero so the word bus is clean after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/event_readout_ctrl.sv
// Sequences a pixel arbitration hierarchy and streams timestamped events.
// Optional build macro: EVT_FRAME_MARKER_EN (push a marker word per frame).
module event_readout_ctrl
    import erc_pkg::*;
#(
    parameter  int X_W        = 4,
    parameter  int Y_W        = 4,
    parameter  int TS_W       = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int FC_W       = 8,
    localparam int EVT_W      = evt_w(TS_W, X_W, Y_W)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             run_i,
    input  logic             req_i,
    input  logic             active_i,
    input  logic [X_W-1:0]   x_add_i,
    input  logic [Y_W-1:0]   y_add_i,
    input  logic             grp_release_i,
    output logic             enable_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [EVT_W-1:0] evt_data_o,
    output logic             frame_done_o,
    output logic [FC_W-1:0]  frame_cnt_o,
    output logic             drop_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    erc_state_e       state;
    logic [TS_W-1:0]  ts;
    logic [CW-1:0]    count;
    logic [CW-1:0]    cnt_after;
    logic             full;
    logic             empty;
    logic             cap;
    logic             push;
    logic             pop_eff;
    logic             push_ok;
    logic [EVT_W-1:0] wdata;
    logic             rel_pend;
    logic             rel_seen;
    logic             go_done;
    logic             wait_slot;

    assign cap      = active_i & ((state == SCAN) | (state == HOLD));
    assign rel_seen = grp_release_i | rel_pend;

`ifdef EVT_FRAME_MARKER_EN
    localparam int XY_W = X_W + Y_W;

    logic mark;

    assign mark      = (state == DONE);
    assign push      = cap | mark;
    assign wdata     = mark ? {1'b1, ts, XY_W'(frame_cnt_o)}
                            : {1'b0, ts, x_add_i, y_add_i};
    // The marker needs a slot in DONE, so only leave SCAN when one is free.
    assign go_done   = rel_seen & (cnt_after < CW'(FIFO_DEPTH));
    assign wait_slot = rel_seen & ~go_done;
`else
    assign push      = cap;
    assign wdata     = {1'b0, ts, x_add_i, y_add_i};
    assign go_done   = rel_seen;
    assign wait_slot = 1'b0;
`endif

    assign pop_eff   = evt_ready_i & ~empty;
    assign push_ok   = push & (~full | pop_eff);
    assign cnt_after = count + CW'(push_ok);

    assign evt_valid_o = ~empty;

    evt_sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .wdata   (wdata),
        .pop     (evt_ready_i),
        .rdata   (evt_data_o),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Free-running timestamp.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Scan sequencer with registered enable, frame pulse and drop flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            enable_o     <= 1'b0;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= '0;
            drop_o       <= 1'b0;
            rel_pend     <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (push & ~push_ok) begin
                drop_o <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (run_i & req_i &
                        (count <= CW'(FIFO_DEPTH - HOLD_MARGIN - 1))) begin
                        state    <= SCAN;
                        enable_o <= 1'b1;
                    end
                end
                SCAN: begin
                    if (go_done) begin
                        state        <= DONE;
                        enable_o     <= 1'b0;
                        rel_pend     <= 1'b0;
                        frame_done_o <= 1'b1;
                        frame_cnt_o  <= frame_cnt_o + FC_W'(1);
                    end else if (wait_slot) begin
                        rel_pend <= 1'b1;
                        enable_o <= 1'b0;
                    end else if (cnt_after >=
                                 CW'(FIFO_DEPTH - HOLD_MARGIN)) begin
                        state    <= HOLD;
                        enable_o <= 1'b0;
                    end else if (!run_i) begin
                        state    <= IDLE;
                        enable_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!run_i) begin
                        state <= IDLE;
                    end else if (count <=
                                 CW'(FIFO_DEPTH - RESUME_MARGIN)) begin
                        state    <= SCAN;
                        enable_o <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_readout_ctrl.sv
// Scoreboard bench for event_readout_ctrl (default and TS_W=4 instances).
// Build with EVT_FRAME_MARKER_EN to also expect frame marker words.
module tb_event_readout_ctrl;

    localparam int EW  = erc_pkg::evt_w(16, 4, 4);
    localparam int EW2 = erc_pkg::evt_w(4, 4, 4);

    logic clk = 1'b0;
    logic reset_i, run_i, req_i, active_i, grp_release_i, evt_ready_i;
    logic [3:0] x_add_i, y_add_i;

    logic          enable_o, evt_valid_o, frame_done_o, drop_o;
    logic [EW-1:0] evt_data_o;
    logic [7:0]    frame_cnt_o;

    logic           enable2, evt_valid2, frame_done2, drop2;
    logic [EW2-1:0] evt_data2;
    logic [7:0]     frame_cnt2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int fd_cnt = 0;

    logic [EW-1:0]  q[$];
    logic [EW2-1:0] q2[$];

    event_readout_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .run_i         (run_i),
        .req_i         (req_i),
        .active_i      (active_i),
        .x_add_i       (x_add_i),
        .y_add_i       (y_add_i),
        .grp_release_i (grp_release_i),
        .enable_o      (enable_o),
        .evt_valid_o   (evt_valid_o),
        .evt_ready_i   (evt_ready_i),
        .evt_data_o    (evt_data_o),
        .frame_done_o  (frame_done_o),
        .frame_cnt_o   (frame_cnt_o),
        .drop_o        (drop_o)
    );

    event_readout_ctrl #(.TS_W(4)) dut2 (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .run_i         (run_i),
        .req_i         (req_i),
        .active_i      (active_i),
        .x_add_i       (x_add_i),
        .y_add_i       (y_add_i),
        .grp_release_i (grp_release_i),
        .enable_o      (enable2),
        .evt_valid_o   (evt_valid2),
        .evt_ready_i   (evt_ready_i),
        .evt_data_o    (evt_data2),
        .frame_done_o  (frame_done2),
        .frame_cnt_o   (frame_cnt2),
        .drop_o        (drop2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every accepted word against the scoreboard.
    always @(negedge clk) begin
        logic [EW-1:0]  w;
        logic [EW2-1:0] w2;
        if (!reset_i) begin
            if (frame_done_o) fd_cnt++;
            if (evt_valid_o && evt_ready_i) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL evt_word: unexpected %h", evt_data_o);
                end else begin
                    w = q.pop_front();
                    if (evt_data_o !== w) begin
                        fails++;
                        $display("FAIL evt_word: got %h, expected %h",
                                 evt_data_o, w);
                    end
                end
            end
            if (evt_valid2 && evt_ready_i) begin
                checks++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL evt_word_ts4: unexpected %h", evt_data2);
                end else begin
                    w2 = q2.pop_front();
                    if (evt_data2 !== w2) begin
                        fails++;
                        $display("FAIL evt_word_ts4: got %h, expected %h",
                                 evt_data2, w2);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] x, input logic [3:0] y);
        q.push_back({1'b0, cyc[15:0], x, y});
        q2.push_back({1'b0, cyc[3:0], x, y});
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        run_i = 1'b0;
        req_i = 1'b0;
        active_i = 1'b0;
        grp_release_i = 1'b0;
        evt_ready_i = 1'b0;
        x_add_i = '0;
        y_add_i = '0;
        tick();
        tick();
        reset_i = 1'b0;
        q.delete();
        q2.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_enable"}, enable_o, 0);
        chk({tag, "_valid"}, evt_valid_o, 0);
        chk({tag, "_data"}, evt_data_o, 0);
        chk({tag, "_fdone"}, frame_done_o, 0);
        chk({tag, "_fcnt"}, frame_cnt_o, 0);
        chk({tag, "_drop"}, drop_o, 0);
    endtask

    // Hierarchy model: active_o is enable_i delayed by one cycle.
    task automatic fill_to_hold(output int fall_sz);
        logic prev_en = 1'b0;
        fall_sz = -1;
        for (int i = 0; i < 14; i++) begin
            if (!enable_o && prev_en) fall_sz = q.size();
            active_i = prev_en;
            x_add_i = i[3:0];
            y_add_i = 4'hf - i[3:0];
            if (prev_en) push_exp(x_add_i, y_add_i);
            prev_en = enable_o;
            tick();
        end
        active_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        evt_ready_i = 1'b1;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        chk(name, q.size(), 0);
        chk({name, "_valid"}, evt_valid_o, 0);
    endtask

    initial begin
        int fall_sz;
        int rise_sz;
        int last_sz;
        int fd0;
        logic prev_en;

        // Reset state
        do_reset();
        chk_zero("reset");

        // Single frame, three grants, then group release
        evt_ready_i = 1'b1;
        run_i = 1'b1;
        req_i = 1'b1;
        while (cyc < 10) tick();
        chk("t1_enable", enable_o, 1);
        active_i = 1'b1; x_add_i = 4'd2; y_add_i = 4'd3;
        push_exp(x_add_i, y_add_i);
        tick();
        active_i = 1'b0;
        tick();
        active_i = 1'b1; x_add_i = 4'd5; y_add_i = 4'd1;
        push_exp(x_add_i, y_add_i);
        tick();
        active_i = 1'b0;
        tick();
        active_i = 1'b1; x_add_i = 4'd7; y_add_i = 4'd7;
        push_exp(x_add_i, y_add_i);
        tick();
        active_i = 1'b0;
        grp_release_i = 1'b1;
        run_i = 1'b0;
        req_i = 1'b0;
        tick();
        grp_release_i = 1'b0;
        chk("t1_fdone_pulse", frame_done_o, 1);
        chk("t1_fcnt_done", frame_cnt_o, 1);
        chk("t1_enable_done", enable_o, 0);
`ifdef EVT_FRAME_MARKER_EN
        q.push_back({1'b1, cyc[15:0], 8'h01});
        q2.push_back({1'b1, cyc[3:0], 8'h01});
`endif
        tick();
        chk("t1_fdone_low", frame_done_o, 0);
        repeat (5) tick();
        chk("t1_fd_count", fd_cnt, 1);
        chk("t1_fcnt", frame_cnt_o, 1);
        chk("t1_drained", q.size(), 0);

        // Throttle with a stalled sink, then resume
        do_reset();
        run_i = 1'b1;
        req_i = 1'b1;
        fill_to_hold(fall_sz);
        chk("t2_fall_count", fall_sz, 6);
        chk("t2_enable_hold", enable_o, 0);
        chk("t2_count_trail", q.size(), 7);
        chk("t2_drop", drop_o, 0);
        chk("t2_valid", evt_valid_o, 1);
        evt_ready_i = 1'b1;
        prev_en = 1'b0;
        rise_sz = -1;
        last_sz = q.size();
        for (int i = 0; i < 20; i++) begin
            if (enable_o) begin
                rise_sz = last_sz;
                break;
            end
            last_sz = q.size();
            tick();
        end
        chk("t2_resume_count", rise_sz, 4);
        run_i = 1'b0;
        req_i = 1'b0;
        drain("t2_drain");
        chk("t2_idle_enable", enable_o, 0);

        // Forced grant into a full FIFO
        do_reset();
        run_i = 1'b1;
        req_i = 1'b1;
        fill_to_hold(fall_sz);
        active_i = 1'b1; x_add_i = 4'ha; y_add_i = 4'hb;
        push_exp(x_add_i, y_add_i);
        tick();
        chk("t3_drop_at_full", drop_o, 0);
        x_add_i = 4'hc; y_add_i = 4'hd;
        tick();
        active_i = 1'b0;
        tick();
        chk("t3_drop_set", drop_o, 1);
        chk("t3_count_full", q.size(), 8);
        repeat (3) tick();
        chk("t3_drop_sticky", drop_o, 1);
        run_i = 1'b0;
        drain("t3_drain");
        chk("t3_drop_after", drop_o, 1);

        // Push and pop together on a full FIFO
        do_reset();
        chk("t3b_drop_reset", drop_o, 0);
        run_i = 1'b1;
        req_i = 1'b1;
        fill_to_hold(fall_sz);
        active_i = 1'b1; x_add_i = 4'h1; y_add_i = 4'h2;
        push_exp(x_add_i, y_add_i);
        tick();
        evt_ready_i = 1'b1;
        x_add_i = 4'h3; y_add_i = 4'h4;
        push_exp(x_add_i, y_add_i);
        tick();
        evt_ready_i = 1'b0;
        active_i = 1'b0;
        tick();
        chk("t3b_drop", drop_o, 0);
        chk("t3b_count", q.size(), 8);
        run_i = 1'b0;
        req_i = 1'b0;
        drain("t3b_drain");
        chk("t3b_drop_end", drop_o, 0);

        // Timestamp wrap on the TS_W=4 instance
        do_reset();
        evt_ready_i = 1'b1;
        run_i = 1'b1;
        req_i = 1'b1;
        while (cyc < 17) tick();
        chk("t4_enable", enable2, 1);
        active_i = 1'b1; x_add_i = 4'd4; y_add_i = 4'd9;
        push_exp(x_add_i, y_add_i);
        tick();
        active_i = 1'b0;
        chk("t4_word_ts4", evt_data2, 13'h0149);
        repeat (3) tick();
        chk("t4_drained_ts4", q2.size(), 0);
        run_i = 1'b0;
        req_i = 1'b0;
        tick();

        // run_i dropped mid-scan
        do_reset();
        evt_ready_i = 1'b1;
        run_i = 1'b1;
        req_i = 1'b1;
        fd0 = fd_cnt;
        tick();
        tick();
        chk("t5_enable", enable_o, 1);
        active_i = 1'b1; x_add_i = 4'd1; y_add_i = 4'd2;
        push_exp(x_add_i, y_add_i);
        tick();
        active_i = 1'b0;
        run_i = 1'b0;
        tick();
        chk("t5_enable_off", enable_o, 0);
        repeat (3) tick();
        chk("t5_idle_enable", enable_o, 0);
        chk("t5_no_fdone", fd_cnt, fd0);
        chk("t5_fcnt", frame_cnt_o, 0);
        chk("t5_drained", q.size(), 0);

        // Reset in the middle of a frame
        evt_ready_i = 1'b0;
        run_i = 1'b1;
        tick();
        tick();
        active_i = 1'b1; x_add_i = 4'd3; y_add_i = 4'd3;
        tick();
        x_add_i = 4'd3; y_add_i = 4'd4;
        tick();
        active_i = 1'b0;
        chk("t6_valid_pre", evt_valid_o, 1);
        chk("t6_enable_pre", enable_o, 1);
        reset_i = 1'b1;
        tick();
        chk_zero("t6");
        reset_i = 1'b0;
        run_i = 1'b0;
        req_i = 1'b0;
        q.delete();
        q2.delete();
        repeat (2) tick();
        chk("t6_valid_post", evt_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
